// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b memory-side types plus the arbiter state encoding.
package lc3b_types;
  typedef logic [127:0] lc3b_line;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [15:0]  lc3b_mem_sel;
  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} lc3b_arb_state;
  localparam lc3b_mem_sel SEL_ALL = 16'hFFFF;
endpackage

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: round-robin arbiter serialising I-fetch and data line requests onto one memory port.
module lc3b_mem_arbiter
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_read,
  input  lc3b_wb_adr  ifetch_address,
  output lc3b_line    ifetch_rdata,
  output logic        ifetch_resp,
  input  logic        mem_read,
  input  logic        mem_write,
  input  lc3b_wb_adr  mem_address,
  input  lc3b_line    mem_wdata,
  input  lc3b_mem_sel mem_sel,
  output lc3b_line    mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_wb_adr  pmem_address,
  output lc3b_c_line  pmem_wdata,
  output lc3b_mem_sel pmem_sel,
  input  lc3b_c_line  pmem_rdata,
  input  logic        pmem_resp
);
  lc3b_arb_state state_q, state_d;
  logic          last_grant_q, last_grant_d;
  lc3b_wb_adr    addr_q, addr_d;
  lc3b_c_line    wdata_q, wdata_d;
  lc3b_mem_sel   sel_q, sel_d;
  logic          write_q, write_d;
  lc3b_line      line_q, line_d;
  logic          busy, d_req, grant_d_side;
  // last_grant: 0 = I-side, 1 = D-side; a tie goes to the side not served last
  assign d_req        = mem_read | mem_write;
  assign grant_d_side = d_req & (~ifetch_read | ~last_grant_q);
  assign busy         = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign pmem_read    = busy & ~write_q;
  assign pmem_write   = busy & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_sel     = sel_q;
  assign ifetch_resp  = state_q == I_DONE;
  assign mem_resp     = state_q == D_DONE;
  assign ifetch_rdata = line_q;
  assign mem_rdata    = line_q;
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    write_d      = write_q;
    line_d       = line_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d_side) begin
          state_d      = D_BUSY;
          last_grant_d = 1'b1;
          addr_d       = mem_address;
          wdata_d      = mem_wdata;
          sel_d        = mem_sel;
          write_d      = mem_write;
        end else if (ifetch_read) begin
          state_d      = I_BUSY;
          last_grant_d = 1'b0;
          addr_d       = ifetch_address;
          wdata_d      = '0;
          sel_d        = SEL_ALL;
          write_d      = 1'b0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d = (state_q == I_BUSY) ? I_DONE : D_DONE;
          line_d  = write_q ? line_q : pmem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      write_q      <= 1'b0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      write_q      <= write_d;
      line_q       <= line_d;
    end
  end
endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb_lc3b_mem_arbiter: directed scoreboard bench with a wait-programmable memory responder.
module tb_lc3b_mem_arbiter;
  import lc3b_types::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_read = 1'b0;
  lc3b_wb_adr  ifetch_address = '0;
  lc3b_line    ifetch_rdata;
  logic        ifetch_resp;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  lc3b_wb_adr  mem_address = '0;
  lc3b_line    mem_wdata = '0;
  lc3b_mem_sel mem_sel = '0;
  lc3b_line    mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  lc3b_wb_adr  pmem_address;
  lc3b_c_line  pmem_wdata;
  lc3b_mem_sel pmem_sel;
  lc3b_c_line  pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  typedef struct {logic d; lc3b_line line;} exp_t;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0;
  int mem_wait = 0, wcnt = 0, cyc;
  logic stray = 1'b0;
  lc3b_line last_line, wline;

  lc3b_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
    .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_sel(pmem_sel), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic lc3b_line line_of(input lc3b_wb_adr a);
    return {{10{a}}, 8'hBC} ^ {{9{12'hABC}}, 20'h0};
  endfunction

  // memory model: answers after mem_wait busy cycles, updates after the bench's negedge drive
  always @(negedge clk) begin
    #1;
    if (pmem_read | pmem_write) begin
      pmem_resp  = stray | (wcnt == mem_wait);
      pmem_rdata = line_of(pmem_address);
      wcnt++;
    end else begin
      wcnt = 0;
      pmem_resp = stray;
    end
  end

  always @(negedge clk)
    assert (!(mem_read && mem_write)) else begin
      n_fail++;
      $error("FAIL illegal_rw observed=both_high expected=not_both");
    end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(output int c);
    logic seen;
    exp_t e;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 30) begin
      @(negedge clk);
      c++;
      seen = ifetch_resp | mem_resp;
    end
    check("resp_seen", 128'(seen), 128'(1));
    check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      check("resp_side", 128'({mem_resp, ifetch_resp}), 128'(e.d ? 2'b10 : 2'b01));
      check("resp_data", e.d ? mem_rdata : ifetch_rdata, e.line);
      check("done_strobes", 128'({pmem_read, pmem_write}), 128'(0));
      last_line = e.line;
    end
  endtask

  task automatic post_resp();
    @(negedge clk);
    check("post_resp_pulse", 128'({mem_resp, ifetch_resp}), 128'(0));
    check("post_resp_state", 128'(dut.state_q), 128'(IDLE));
  endtask

  initial begin
    last_line = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 128'(dut.state_q), 128'(IDLE));
    check("reset_strobes", 128'({pmem_read, pmem_write, ifetch_resp, mem_resp}), 128'(0));
    check("reset_line", mem_rdata, 128'(0));
    rst = 1'b0;
    // reset while a D read is in flight
    mem_wait = 20;
    mem_read = 1'b1;
    mem_address = 12'h040;
    @(negedge clk);
    check("midbusy_state", 128'(dut.state_q), 128'(D_BUSY));
    check("midbusy_addr", 128'(pmem_address), 128'(12'h040));
    check("midbusy_read", 128'(pmem_read), 128'(1));
    rst = 1'b1;
    #1;
    check("midbusy_async_strobe", 128'({pmem_read, pmem_write}), 128'(0));
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midbusy_idle", 128'(dut.state_q), 128'(IDLE));
      check("midbusy_noresp", 128'({mem_resp, ifetch_resp}), 128'(0));
    end
    // lone I-fetch, three wait cycles
    mem_wait = 3;
    ifetch_read = 1'b1;
    ifetch_address = 12'h123;
    sb.push_back('{1'b0, line_of(12'h123)});
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check("ifetch_busy", 128'({pmem_read, pmem_write}), 128'(2'b10));
      check("ifetch_addr", 128'(pmem_address), 128'(12'h123));
      check("ifetch_sel", 128'(pmem_sel), 128'(16'hFFFF));
    end
    wait_resp(cyc);
    check("ifetch_resp_lat", 128'(cyc), 128'(1));
    ifetch_read = 1'b0;
    post_resp();
    // zero-wait D read
    mem_wait = 0;
    mem_read = 1'b1;
    mem_address = 12'h055;
    sb.push_back('{1'b1, line_of(12'h055)});
    wait_resp(cyc);
    check("dread_lat", 128'(cyc), 128'(2));
    check("dread_no_iresp", 128'(ifetch_resp), 128'(0));
    mem_read = 1'b0;
    post_resp();
    // masked write; requester inputs scrambled while busy
    mem_wait = 2;
    wline = 128'h0;
    wline[47:32] = 16'hBEEF;
    mem_write = 1'b1;
    mem_address = 12'h077;
    mem_sel = 16'h0030;
    mem_wdata = wline;
    sb.push_back('{1'b1, last_line});
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      check("wr_strobe", 128'({pmem_read, pmem_write}), 128'(2'b01));
      check("wr_addr", 128'(pmem_address), 128'(12'h077));
      check("wr_wdata", pmem_wdata, wline);
      check("wr_sel", 128'(pmem_sel), 128'(16'h0030));
      mem_wdata = '1;
      mem_sel = 16'hFFFF;
      mem_address = 12'h000;
    end
    wait_resp(cyc);
    mem_write = 1'b0;
    post_resp();
    check("wr_line_stable", ifetch_rdata, last_line);
    // contention from reset: D, I, D, I
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_wait = 1;
    ifetch_read = 1'b1;
    ifetch_address = 12'h200;
    mem_read = 1'b1;
    mem_address = 12'h300;
    mem_sel = '0;
    mem_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, line_of(12'h300)});
      sb.push_back('{1'b0, line_of(12'h200)});
    end
    for (int i = 0; i < 4; i++) begin
      wait_resp(cyc);
      if (i == 3) begin
        ifetch_read = 1'b0;
        mem_read = 1'b0;
      end
      post_resp();
    end
    // stray memory response while idle
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_state", 128'(dut.state_q), 128'(IDLE));
      check("stray_noresp", 128'({mem_resp, ifetch_resp}), 128'(0));
    end
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
